// File: rtl/pll_reset_sequencer.sv
// PLL lock qualifier and system reset sequencer.
// Filters the PLL lock flag, releases sys_reset, and drives the pixel strobe.
module pll_reset_sequencer #(
  parameter int LOCK_FILTER = 1024,
  parameter int RESET_HOLD  = 16,
  parameter int PIXEL_DIV   = 8
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       locked,
  input  logic       lock_lost_clear,
  output logic       sys_reset,
  output logic       ready,
  output logic       pixel_stb,
  output logic [7:0] lock_lost_count
);

  localparam int CMAX = (LOCK_FILTER > RESET_HOLD) ?
                        LOCK_FILTER : RESET_HOLD;
  localparam int CW = $clog2((CMAX > 2) ? CMAX : 2);
  localparam int PW = $clog2((PIXEL_DIV > 2) ? PIXEL_DIV : 2);

  localparam logic [CW-1:0] FILT_LAST = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(RESET_HOLD - 1);
  localparam logic [PW-1:0] PDIV_LAST = PW'(PIXEL_DIV - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    FILTER,
    HOLD,
    RUN
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [PW-1:0] pdiv_q;
  logic [PW-1:0] pdiv_d;
  logic [1:0]    sync_q;
  logic          locked_sync;
  logic          loss;
  logic          run_d;
  logic          stb_d;
  logic [7:0]    llc_base;
  logic [7:0]    llc_d;

  // locked comes from the PLL's own domain logic; treat as async
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], locked};
    end
  end

  assign locked_sync = sync_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    loss    = 1'b0;
    unique case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (locked_sync) state_d = FILTER;
      end
      FILTER: begin
        if (!locked_sync) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == FILT_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (!locked_sync) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        cnt_d = '0;
        if (!locked_sync) begin
          state_d = WAIT_LOCK;
          loss    = 1'b1;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  // pixel divider only runs while staying in RUN
  always_comb begin
    run_d  = (state_d == RUN);
    pdiv_d = '0;
    stb_d  = 1'b0;
    if (run_d && state_q == RUN) begin
      pdiv_d = (pdiv_q == PDIV_LAST) ? '0 : pdiv_q + 1'b1;
    end
    if (run_d) begin
      if (PIXEL_DIV == 1) begin
        stb_d = 1'b1;
      end else begin
        stb_d = (state_q == RUN) && (pdiv_q == PDIV_LAST);
      end
    end
  end

  // clear wins first, then a coincident loss counts on top of it
  always_comb begin
    llc_base = lock_lost_clear ? 8'd0 : lock_lost_count;
    llc_d    = llc_base;
    if (loss && llc_base != 8'hFF) begin
      llc_d = llc_base + 8'd1;
    end
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q         <= WAIT_LOCK;
      cnt_q           <= '0;
      pdiv_q          <= '0;
      sys_reset       <= 1'b1;
      ready           <= 1'b0;
      pixel_stb       <= 1'b0;
      lock_lost_count <= 8'd0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      pdiv_q          <= pdiv_d;
      sys_reset       <= ~run_d;
      ready           <= run_d;
      pixel_stb       <= stb_d;
      lock_lost_count <= llc_d;
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer.
// Second instance runs the PIXEL_DIV=1 build alongside.
module tb_pll_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       locked = 1'b0;
  logic       clr = 1'b0;
  logic       sys_reset;
  logic       ready;
  logic       stb;
  logic [7:0] llc;
  logic       sys_reset1;
  logic       ready1;
  logic       stb1;
  logic [7:0] llc1;

  int tests = 0;
  int fails = 0;
  int pd1_bad = 0;

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .LOCK_FILTER(8),
    .RESET_HOLD (4),
    .PIXEL_DIV  (3)
  ) dut (
    .clock_in       (clk),
    .reset          (reset),
    .locked         (locked),
    .lock_lost_clear(clr),
    .sys_reset      (sys_reset),
    .ready          (ready),
    .pixel_stb      (stb),
    .lock_lost_count(llc)
  );

  pll_reset_sequencer #(
    .LOCK_FILTER(8),
    .RESET_HOLD (4),
    .PIXEL_DIV  (1)
  ) dut1 (
    .clock_in       (clk),
    .reset          (reset),
    .locked         (locked),
    .lock_lost_clear(clr),
    .sys_reset      (sys_reset1),
    .ready          (ready1),
    .pixel_stb      (stb1),
    .lock_lost_count(llc1)
  );

  always @(negedge clk) begin
    if (stb1 !== ready1) pd1_bad = pd1_bad + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1 reset = 1'b1;
    #1;
    chk("rst_sys_reset", 32'(sys_reset), 1);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_stb", 32'(stb), 0);
    chk("rst_llc", 32'(llc), 0);
    tick(2);
    reset = 1'b0;

    // T1: lock from edge 0
    tick(1);
    locked = 1'b1;
    tick(14);
    chk("t1_sysrst_e14", 32'(sys_reset), 1);
    chk("t1_ready_e14", 32'(ready), 0);
    chk("t1_pd1_e14", 32'(stb1), 0);
    tick(1);
    chk("t1_sysrst_e15", 32'(sys_reset), 0);
    chk("t1_ready_e15", 32'(ready), 1);
    chk("t1_stb_e15", 32'(stb), 0);
    chk("t1_pd1_e15", 32'(stb1), 1);
    tick(2);
    chk("t1_stb_e17", 32'(stb), 0);
    tick(1);
    chk("t1_stb_e18", 32'(stb), 1);
    tick(1);
    chk("t1_stb_e19", 32'(stb), 0);
    tick(2);
    chk("t1_stb_e21", 32'(stb), 1);
    tick(3);
    chk("t1_stb_e24", 32'(stb), 1);
    chk("t1_llc", 32'(llc), 0);

    // T3: loss in RUN at edge m=24
    locked = 1'b0;
    tick(2);
    chk("t3_sysrst_m2", 32'(sys_reset), 0);
    tick(1);
    chk("t3_sysrst_m3", 32'(sys_reset), 1);
    chk("t3_ready_m3", 32'(ready), 0);
    chk("t3_stb_m3", 32'(stb), 0);
    chk("t3_llc_m3", 32'(llc), 1);
    locked = 1'b1;
    tick(14);
    chk("t3_relock_e14", 32'(sys_reset), 1);
    tick(1);
    chk("t3_relock_e15", 32'(sys_reset), 0);
    chk("t3_llc_keep", 32'(llc), 1);

    // T5a: async reset in RUN
    #2 reset = 1'b1;
    #1;
    chk("t5r_sysrst", 32'(sys_reset), 1);
    chk("t5r_ready", 32'(ready), 0);
    chk("t5r_stb", 32'(stb), 0);
    chk("t5r_llc", 32'(llc), 0);
    chk("t5r_pd1", 32'(stb1), 0);
    locked = 1'b0;
    tick(2);
    reset = 1'b0;

    // T2: glitch during filter
    tick(1);
    locked = 1'b1;
    tick(5);
    locked = 1'b0;
    tick(1);
    locked = 1'b1;
    tick(9);
    chk("t2_no_early", 32'(sys_reset), 1);
    tick(5);
    chk("t2_e14", 32'(sys_reset), 1);
    tick(1);
    chk("t2_e15", 32'(sys_reset), 0);
    chk("t2_llc", 32'(llc), 0);

    // T4: saturation over 300 losses
    for (int i = 0; i < 300; i++) begin
      locked = 1'b0;
      tick(3);
      locked = 1'b1;
      tick(15);
      if (i == 253) chk("t4_llc_254", 32'(llc), 254);
      if (i == 254) chk("t4_llc_255", 32'(llc), 255);
    end
    chk("t4_ready", 32'(ready), 1);
    chk("t4_llc_sat", 32'(llc), 255);
    locked = 1'b0;
    tick(2);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("t4_clr_loss", 32'(llc), 1);
    chk("t4_clr_sysrst", 32'(sys_reset), 1);
    locked = 1'b1;
    tick(1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("t4_clr_only", 32'(llc), 0);
    tick(20);
    chk("t4_rerun", 32'(ready), 1);

    // T5b: async reset in HOLD
    #2 reset = 1'b1;
    #1;
    chk("t5a_sysrst", 32'(sys_reset), 1);
    tick(1);
    reset = 1'b0;
    tick(12);
    chk("t5h_pre", 32'(sys_reset), 1);
    #2 reset = 1'b1;
    #1;
    chk("t5h_sysrst", 32'(sys_reset), 1);
    chk("t5h_ready", 32'(ready), 0);
    chk("t5h_stb", 32'(stb), 0);
    tick(1);
    reset = 1'b0;
    tick(14);
    chk("t5h_e14", 32'(sys_reset), 1);
    tick(1);
    chk("t5h_e15", 32'(sys_reset), 0);
    chk("t5h_ready15", 32'(ready), 1);
    tick(3);

    chk("t6_pd1_track", 32'(pd1_bad), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
